// File: rtl/sfm_pkg.sv
// Shared softmax-datapath types: accumulator state encoding, accumulator flag
// bundle and the default accumulator width.
package sfm_pkg;

   localparam int unsigned DEFAULT_ACC_WIDTH = 32;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      REDUCE = 2'd1,
      DONE   = 2'd2
   } sfm_acc_state_t;

   typedef struct packed {
      logic reducing;
      logic sum_valid;
      logic overflow;
   } accumulator_flags_t;

endpackage

// File: rtl/sfm_sat_adder.sv
// Unsigned saturating adder.
// Ports:
//   a_i, b_i  in   WIDTH  addends
//   sum_o     out  WIDTH  a_i + b_i, clamped to all-ones
//   sat_o     out  1      the true sum did not fit in WIDTH bits
module sfm_sat_adder
   import sfm_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_ACC_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             sat_o
);

   logic [WIDTH:0] full_sum;

   assign full_sum = {1'b0, a_i} + {1'b0, b_i};
   assign sat_o    = full_sum[WIDTH];
   assign sum_o    = sat_o ? '1 : full_sum[WIDTH-1:0];

endmodule

// File: rtl/sfm_accumulator.sv
// Softmax denominator accumulator. Sums per-lane exponentiated values during
// pass 1, then sequentially reduces the lane sums to one scalar for the divider.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   clear_i          sync clear, highest priority
//   enable_i         global enable; low freezes all state
//   acc_finished_i   end of pass 1, starts the reduction
//   valid_i/ready_o  input beat handshake (ready only while accumulating)
//   data_i, strb_i   lane values and lane enables
//   reducing_o       reduction in progress
//   sum_valid_o      sum_o final and stable
//   sum_o            reduced denominator
//   overflow_o       sticky saturation flag
module sfm_accumulator
   import sfm_pkg::*;
#(
   parameter int unsigned N_LANES   = 8,
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic                        enable_i,
   input  logic                        acc_finished_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [N_LANES*IN_WIDTH-1:0] data_i,
   input  logic [N_LANES-1:0]          strb_i,
   output logic                        reducing_o,
   output logic                        sum_valid_o,
   output logic [ACC_WIDTH-1:0]        sum_o,
   output logic                        overflow_o
);

   localparam int unsigned IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

   // Reject configurations the datapath cannot support
   if (N_LANES < 2) begin : g_bad_lanes
      $error("sfm_accumulator: N_LANES must be >= 2");
   end
   if (ACC_WIDTH <= IN_WIDTH) begin : g_bad_width
      $error("sfm_accumulator: ACC_WIDTH must exceed IN_WIDTH");
   end

   sfm_acc_state_t     state_q;
   accumulator_flags_t flags_q;
   logic [ACC_WIDTH-1:0] lane_acc_q [N_LANES];
   logic [ACC_WIDTH-1:0] total_q;
   logic [IDX_W-1:0]     idx_q;

   logic [ACC_WIDTH-1:0] lane_in  [N_LANES];
   logic [ACC_WIDTH-1:0] lane_sum [N_LANES];
   logic [N_LANES-1:0]   lane_sat;
   logic [ACC_WIDTH-1:0] red_sum;
   logic                 red_sat;
   logic                 handshake;

   assign ready_o   = enable_i && (state_q == ACCUM);
   assign handshake = valid_i && ready_o;

   // Per-lane saturating accumulation; masked lanes add zero
   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      assign lane_in[g] = strb_i[g] ? ACC_WIDTH'(data_i[g*IN_WIDTH +: IN_WIDTH]) : '0;

      sfm_sat_adder #(.WIDTH(ACC_WIDTH)) u_lane_add (
         .a_i   (lane_acc_q[g]),
         .b_i   (lane_in[g]),
         .sum_o (lane_sum[g]),
         .sat_o (lane_sat[g])
      );
   end

   // Sequential reduction: one lane folded into the total per enabled cycle
   sfm_sat_adder #(.WIDTH(ACC_WIDTH)) u_red_add (
      .a_i   (total_q),
      .b_i   (lane_acc_q[idx_q]),
      .sum_o (red_sum),
      .sat_o (red_sat)
   );

   // State, accumulators and registered flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ACCUM;
         flags_q <= '0;
         total_q <= '0;
         idx_q   <= '0;
         for (int unsigned i = 0; i < N_LANES; i++) lane_acc_q[i] <= '0;
      end else if (clear_i) begin
         state_q <= ACCUM;
         flags_q <= '0;
         total_q <= '0;
         idx_q   <= '0;
         for (int unsigned i = 0; i < N_LANES; i++) lane_acc_q[i] <= '0;
      end else if (enable_i) begin
         case (state_q)
            ACCUM: begin
               // A beat taken alongside acc_finished_i still lands before reduction
               if (handshake) begin
                  for (int unsigned i = 0; i < N_LANES; i++) lane_acc_q[i] <= lane_sum[i];
                  if (|lane_sat) flags_q.overflow <= 1'b1;
               end
               if (acc_finished_i) begin
                  state_q          <= REDUCE;
                  flags_q.reducing <= 1'b1;
                  idx_q            <= '0;
               end
            end
            REDUCE: begin
               total_q <= red_sum;
               if (red_sat) flags_q.overflow <= 1'b1;
               if (idx_q == IDX_W'(N_LANES - 1)) begin
                  state_q           <= DONE;
                  flags_q.reducing  <= 1'b0;
                  flags_q.sum_valid <= 1'b1;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
               // DONE holds the result until clear or reset
            end
         endcase
      end
   end

   assign reducing_o  = flags_q.reducing;
   assign sum_valid_o = flags_q.sum_valid;
   assign overflow_o  = flags_q.overflow;
   assign sum_o       = total_q;

endmodule

// File: tb/tb_sfm_accumulator.sv
// Bench for sfm_accumulator: two instances (ACC_WIDTH 32 and 17) share stimulus.
module tb_sfm_accumulator;

   localparam int unsigned NL = 4;
   localparam int unsigned IW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, clear, enable, fin, valid;
   logic [NL*IW-1:0] data;
   logic [NL-1:0]  strb;

   logic        rdy_a, red_a, sv_a, ov_a;
   logic [31:0] sum_a;
   logic        rdy_b, red_b, sv_b, ov_b;
   logic [16:0] sum_b;

   sfm_accumulator #(.N_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(32)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
      .acc_finished_i(fin), .valid_i(valid), .ready_o(rdy_a), .data_i(data),
      .strb_i(strb), .reducing_o(red_a), .sum_valid_o(sv_a), .sum_o(sum_a),
      .overflow_o(ov_a)
   );

   sfm_accumulator #(.N_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(17)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
      .acc_finished_i(fin), .valid_i(valid), .ready_o(rdy_b), .data_i(data),
      .strb_i(strb), .reducing_o(red_b), .sum_valid_o(sv_b), .sum_o(sum_b),
      .overflow_o(ov_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: unbounded per-lane sums, clamped only when the result is read
   longint m_raw [NL];

   function automatic void model_clear();
      for (int i = 0; i < NL; i++) m_raw[i] = 0;
   endfunction

   function automatic void model_beat(input logic [NL*IW-1:0] d, input logic [NL-1:0] s);
      for (int i = 0; i < NL; i++)
         if (s[i]) m_raw[i] += longint'(d[i*IW +: IW]);
   endfunction

   function automatic longint model_sum(input int w, output bit ovf);
      longint mx, tot, l;
      mx  = (longint'(1) << w) - 1;
      tot = 0;
      ovf = 1'b0;
      for (int i = 0; i < NL; i++) begin
         l = m_raw[i];
         if (l > mx) begin l = mx; ovf = 1'b1; end
         tot += l;
      end
      if (tot > mx) begin tot = mx; ovf = 1'b1; end
      return tot;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
   endtask

   // One cycle of valid_i; the model only takes the beat if enable_i is high
   task automatic send(input logic [NL*IW-1:0] d, input logic [NL-1:0] s, input bit with_fin);
      valid = 1'b1;
      data  = d;
      strb  = s;
      fin   = with_fin;
      if (enable) model_beat(d, s);
      tick();
      valid = 1'b0;
      fin   = 1'b0;
   endtask

   task automatic finish_pass();
      fin = 1'b1;
      tick();
      fin = 1'b0;
   endtask

   // Runs the reduction to completion, optionally dropping enable_i for a window
   task automatic wait_done(input int stall_at, input int stall_len,
                            output int red_cnt, output int cyc);
      red_cnt = 0;
      cyc     = 0;
      while (!sv_a && cyc < 60) begin
         if (red_a) red_cnt++;
         enable = !(cyc >= stall_at && cyc < stall_at + stall_len);
         tick();
         cyc++;
      end
      enable = 1'b1;
   endtask

   typedef struct {
      logic [NL-1:0][IW-1:0] lanes;
      logic [NL-1:0]         strb;
      int                    beats;
      longint                exp_a;
      bit                    ovf_a;
      longint                exp_b;
      bit                    ovf_b;
   } vec_t;

   vec_t vt [6];

   initial begin
      int  rc, cy, nb, st_at, st_len;
      bit  eo;
      longint es;
      logic [NL*IW-1:0] rd;
      logic [NL-1:0]    rs;

      rst_n = 1'b0; clear = 1'b0; enable = 1'b1; fin = 1'b0; valid = 1'b0;
      data = '0; strb = '0;
      model_clear();

      vt[0] = '{lanes: {16'd4, 16'd3, 16'd2, 16'd1}, strb: 4'hF, beats: 3,
                exp_a: 30, ovf_a: 0, exp_b: 30, ovf_b: 0};
      vt[1] = '{lanes: {16'd40, 16'd30, 16'd20, 16'd10}, strb: 4'b0101, beats: 1,
                exp_a: 40, ovf_a: 0, exp_b: 40, ovf_b: 0};
      vt[2] = '{lanes: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, strb: 4'hF, beats: 3,
                exp_a: 786420, ovf_a: 0, exp_b: 131071, ovf_b: 1};
      vt[3] = '{lanes: {16'd0, 16'd0, 16'd0, 16'hFFFF}, strb: 4'hF, beats: 2,
                exp_a: 131070, ovf_a: 0, exp_b: 131070, ovf_b: 0};
      vt[4] = '{lanes: {16'd1, 16'd0, 16'd0, 16'hFFFF}, strb: 4'hF, beats: 2,
                exp_a: 131072, ovf_a: 0, exp_b: 131071, ovf_b: 1};
      vt[5] = '{lanes: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, strb: 4'h0, beats: 2,
                exp_a: 0, ovf_a: 0, exp_b: 0, ovf_b: 0};

      // Reset state
      #12;
      check("rst_sum", sum_a, 0);
      check("rst_sum_valid", sv_a, 0);
      check("rst_reducing", red_a, 0);
      check("rst_overflow", ov_a, 0);
      check("rst_ready", rdy_a, 1);
      tick();
      rst_n = 1'b1;
      tick();

      // Table-driven passes
      for (int v = 0; v < 6; v++) begin
         do_clear();
         for (int b = 0; b < vt[v].beats; b++) send(vt[v].lanes, vt[v].strb, 1'b0);
         finish_pass();
         wait_done(99, 0, rc, cy);
         check($sformatf("vec%0d_reduce_cycles", v), rc, 4);
         check($sformatf("vec%0d_latency", v), cy, 4);
         check($sformatf("vec%0d_sum_valid", v), sv_a, 1);
         check($sformatf("vec%0d_reducing_low", v), red_a, 0);
         check($sformatf("vec%0d_sum32", v), sum_a, vt[v].exp_a);
         check($sformatf("vec%0d_ovf32", v), ov_a, vt[v].ovf_a);
         check($sformatf("vec%0d_sum17", v), sum_b, vt[v].exp_b);
         check($sformatf("vec%0d_ovf17", v), ov_b, vt[v].ovf_b);
      end

      // Beat taken in the same cycle as acc_finished
      do_clear();
      send({16'd1, 16'd1, 16'd1, 16'd1}, 4'hF, 1'b1);
      check("simul_ready_low", rdy_a, 0);
      wait_done(99, 0, rc, cy);
      check("simul_sum", sum_a, 4);
      // DONE ignores acc_finished and input beats
      valid = 1'b1; fin = 1'b1; data = '1; strb = '1;
      tick(); tick();
      valid = 1'b0; fin = 1'b0;
      check("done_hold_sum", sum_a, 4);
      check("done_hold_valid", sv_a, 1);
      check("done_ready_low", rdy_a, 0);
      check("done_reducing_low", red_a, 0);
      do_clear();
      check("clear_sum", sum_a, 0);
      check("clear_sum_valid", sv_a, 0);
      check("clear_ready", rdy_a, 1);

      // Sticky overflow in the narrow instance
      for (int b = 0; b < 3; b++) send('1, 4'hF, 1'b0);
      finish_pass();
      wait_done(99, 0, rc, cy);
      tick(); tick(); tick();
      check("sat_sticky_ovf", ov_b, 1);
      check("sat_sticky_sum", sum_b, 17'h1FFFF);
      do_clear();
      check("sat_clear_ovf", ov_b, 0);
      check("sat_clear_sum", sum_b, 0);

      // Enable stall in the middle of the reduction
      for (int b = 0; b < 3; b++) send({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF, 1'b0);
      finish_pass();
      wait_done(2, 3, rc, cy);
      check("stall_reduce_cycles", rc, 7);
      check("stall_sum", sum_a, 30);

      // Async reset in the middle of the reduction
      do_clear();
      send({16'd9, 16'd9, 16'd9, 16'd9}, 4'hF, 1'b0);
      finish_pass();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_reducing", red_a, 0);
      check("arst_sum", sum_a, 0);
      check("arst_ready", rdy_a, 1);
      tick();
      rst_n = 1'b1;
      model_clear();
      send({16'd5, 16'd5, 16'd5, 16'd5}, 4'hF, 1'b0);
      finish_pass();
      wait_done(99, 0, rc, cy);
      check("arst_rerun_sum", sum_a, 20);

      // Randomized passes against the reference model
      for (int it = 0; it < 40; it++) begin
         do_clear();
         nb = int'($urandom_range(1, 6));
         eo = 1'b0;
         for (int b = 0; b < nb; b++) begin
            rd = {$urandom, $urandom};
            rs = NL'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 3) == 0) begin
               enable = 1'b0;
               send({$urandom, $urandom}, 4'hF, 1'b0);
               enable = 1'b1;
            end
            eo = (b == nb - 1) && ($urandom_range(0, 1) == 1);
            send(rd, rs, eo);
         end
         if (!eo) finish_pass();
         st_at  = int'($urandom_range(0, 3));
         st_len = int'($urandom_range(0, 3));
         wait_done(st_at, st_len, rc, cy);
         check($sformatf("rnd%0d_reduce_cycles", it), rc, 4 + st_len);
         check($sformatf("rnd%0d_sum_valid", it), sv_a, 1);
         es = model_sum(32, eo);
         check($sformatf("rnd%0d_sum32", it), sum_a, es);
         check($sformatf("rnd%0d_ovf32", it), ov_a, eo);
         es = model_sum(17, eo);
         check($sformatf("rnd%0d_sum17", it), sum_b, es);
         check($sformatf("rnd%0d_ovf17", it), ov_b, eo);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
